// File: rtl/mem_block_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_if_pkg
// Brief    : Block-width constants and responder state encoding shared by the
//            cache and the memory-side block responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

    localparam int BEATS_PER_BLOCK = 2;
    localparam int BEAT_W          = 16;
    localparam int BLOCK_W         = BEATS_PER_BLOCK * BEAT_W;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LD_WAIT    = 4'd1,
        LD_BEAT0   = 4'd2,
        LD_BEAT1   = 4'd3,
        LD_CAP     = 4'd4,
        LD_DONE    = 4'd5,
        ST_WAIT    = 4'd6,
        ST_BEAT0   = 4'd7,
        ST_BEAT1   = 4'd8,
        ST_DONE    = 4'd9,
        ST_RELEASE = 4'd10
    } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_block_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_block_if
// Brief    : Cache <-> memory block load/store handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_block_if
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0]  address_in;
    logic [BLOCK_W-1:0] data_in;
    logic               mem_load_req;
    logic               mem_store_req;
    logic               store_ack;
    logic [BLOCK_W-1:0] data_out;
    logic               load_completed;
    logic               store_completed;
    logic               load_toggle;

    modport master (
        output address_in, data_in, mem_load_req, mem_store_req, store_ack,
        input  data_out, load_completed, store_completed, load_toggle
    );

    modport slave (
        input  address_in, data_in, mem_load_req, mem_store_req, store_ack,
        output data_out, load_completed, store_completed, load_toggle
    );
endinterface
`default_nettype wire

// File: rtl/mem_block_responder_word_sram.sv
`default_nettype none
// ============================================================================
// Module   : word_sram
// Brief    : Single-port 16-bit SRAM, synchronous write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module word_sram
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [BEAT_W-1:0] i_wdata,
    output logic      [BEAT_W-1:0] o_rdata
);
    logic [BEAT_W-1:0] r_mem [0:(1 << ADDR_W)-1];

    // Storage has no reset so contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end
endmodule
`default_nettype wire

// File: rtl/mem_block_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_block_responder
// Brief    : Sequences one 32-bit block request as two 16-bit SRAM beats after
//            a programmable latency, with four-phase completion handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module mem_block_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 16
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    mem_block_if.slave bus
);
    localparam logic [3:0]  c_cnt_init = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam resp_state_t c_ld_entry = (LATENCY == 0) ? LD_BEAT0 : LD_WAIT;
    localparam resp_state_t c_st_entry = (LATENCY == 0) ? ST_BEAT0 : ST_WAIT;

    resp_state_t        r_state;
    resp_state_t        w_next_state;
    logic [3:0]         r_cnt;
    logic [ADDR_W-3:0]  r_index;
    logic [BLOCK_W-1:0] r_wdata;
    logic [BLOCK_W-1:0] r_data_out;
    logic               r_load_completed;
    logic               r_store_completed;
    logic               r_load_toggle;

    logic               w_sram_we;
    logic [ADDR_W-2:0]  w_sram_addr;
    logic [BEAT_W-1:0]  w_sram_wdata;
    logic [BEAT_W-1:0]  w_sram_rdata;
    logic               w_unused_addr_bits;

    assign w_unused_addr_bits = ^bus.address_in[1:0];

    always_comb begin
        w_next_state = r_state;
        w_sram_we    = 1'b0;
        w_sram_addr  = {r_index, 1'b0};
        w_sram_wdata = r_wdata[BEAT_W-1:0];
        case (r_state)
            IDLE: begin
                if (bus.mem_store_req) begin
                    w_next_state = c_st_entry;
                end else if (bus.mem_load_req) begin
                    w_next_state = c_ld_entry;
                end
            end
            LD_WAIT:  if (r_cnt == 4'd0) w_next_state = LD_BEAT0;
            LD_BEAT0: w_next_state = LD_BEAT1;
            LD_BEAT1: begin
                w_sram_addr  = {r_index, 1'b1};
                w_next_state = LD_CAP;
            end
            LD_CAP:   w_next_state = LD_DONE;
            LD_DONE:  if (!bus.mem_load_req) w_next_state = IDLE;
            ST_WAIT:  if (r_cnt == 4'd0) w_next_state = ST_BEAT0;
            ST_BEAT0: begin
                w_sram_we    = 1'b1;
                w_next_state = ST_BEAT1;
            end
            ST_BEAT1: begin
                w_sram_we    = 1'b1;
                w_sram_addr  = {r_index, 1'b1};
                w_sram_wdata = r_wdata[BLOCK_W-1:BEAT_W];
                w_next_state = ST_DONE;
            end
            // Leave only once completion has actually been presented and acked.
            ST_DONE:    if (r_store_completed && bus.store_ack) w_next_state = ST_RELEASE;
            ST_RELEASE: if (!bus.store_ack) w_next_state = IDLE;
            default:    w_next_state = IDLE;
        endcase
        // A beat whose write cycle coincides with reset is not committed.
        w_sram_we = w_sram_we & rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_cnt             <= 4'd0;
            r_index           <= '0;
            r_wdata           <= '0;
            r_data_out        <= '0;
            r_load_completed  <= 1'b0;
            r_store_completed <= 1'b0;
            r_load_toggle     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && (bus.mem_store_req || bus.mem_load_req)) begin
                r_index <= bus.address_in[ADDR_W-1:2];
                r_cnt   <= c_cnt_init;
                if (bus.mem_store_req) begin
                    r_wdata <= bus.data_in;
                end
            end
            if ((r_state == LD_WAIT || r_state == ST_WAIT) && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == LD_BEAT1) begin
                r_data_out[BEAT_W-1:0] <= w_sram_rdata;
                r_load_toggle          <= ~r_load_toggle;
            end
            if (r_state == LD_CAP) begin
                r_data_out[BLOCK_W-1:BEAT_W] <= w_sram_rdata;
                r_load_toggle                <= ~r_load_toggle;
            end
            r_load_completed  <= (r_state == LD_DONE) && bus.mem_load_req;
            r_store_completed <= (r_state == ST_DONE) && !(r_store_completed && bus.store_ack);
        end
    end

    word_sram #(
        .ADDR_W (ADDR_W - 1)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_sram_we),
        .i_addr  (w_sram_addr),
        .i_wdata (w_sram_wdata),
        .o_rdata (w_sram_rdata)
    );

    assign bus.data_out        = r_data_out;
    assign bus.load_completed  = r_load_completed;
    assign bus.store_completed = r_store_completed;
    assign bus.load_toggle     = r_load_toggle;
endmodule
`default_nettype wire
